// File: rtl/retrosoc_rst_pkg.sv
// retrosoc_rst_pkg: shared state encoding, reset cause codes and counter sizing helper
package retrosoc_rst_pkg;
  typedef enum logic [1:0] {ST_ASSERT, ST_WAIT_LOCK, ST_RELEASE, ST_RUN} state_t;
  localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
  localparam logic [1:0] RST_CAUSE_BTN  = 2'b01;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'b10;
  localparam logic [1:0] RST_CAUSE_SW   = 2'b11;
  // width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/retrosoc_rst_debounce.sv
// retrosoc_rst_debounce: 2-FF synchroniser and low-sample counter for the board reset button
module retrosoc_rst_debounce
  import retrosoc_rst_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_rst_n_i,
  output logic btn_evt_o
);
  localparam int DW = cnt_w(DEB_CYCLES);
  localparam logic [DW-1:0] D_MAX = DW'(DEB_CYCLES - 1);
  logic [1:0] r_sync;
  logic [DW-1:0] r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= 2'b11;
      r_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], btn_rst_n_i};
      r_cnt <= r_sync[1] ? '0 : (r_cnt == D_MAX) ? r_cnt : r_cnt + 1'b1;
    end
  end
  // the current low sample counts toward the threshold, so the press is seen one cycle earlier
  assign btn_evt_o = ~r_sync[1] & (r_cnt == D_MAX);
endmodule

// File: rtl/retrosoc_rst_seq.sv
// retrosoc_rst_seq: board reset sequencer with staggered domain release and sticky reset cause
module retrosoc_rst_seq
  import retrosoc_rst_pkg::*;
#(
  parameter int NUM_RST     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_CYCLES = 8,
  parameter int STAGE_GAP   = 8,
  parameter int DEB_CYCLES  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_rst_n_i,
  input  logic               pll_lock_i,
  input  logic               sw_rst_i,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               sys_ready_o,
  output logic [1:0]         rst_cause_o
);
  localparam int S_MAX = (NUM_RST - 1) * STAGE_GAP;
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int LW = cnt_w(LOCK_CYCLES);
  localparam int SW = cnt_w(S_MAX + 1);
  localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] L_MAX = LW'(LOCK_CYCLES - 1);
  localparam logic [SW-1:0] S_TOP = SW'(S_MAX);
  state_t r_state, w_state_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [LW-1:0] r_lock, w_lock_nx;
  logic [SW-1:0] r_stage, w_stage_nx;
  logic [NUM_RST-1:0] r_rst_n, w_rst_n_nx;
  logic r_ready, w_ready_nx;
  logic [1:0] r_cause, w_cause_nx;
  logic w_btn_evt, w_src, w_lock_loss, w_evt;
  retrosoc_rst_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .btn_rst_n_i(btn_rst_n_i),
    .btn_evt_o(w_btn_evt)
  );
  assign w_src = w_btn_evt | sw_rst_i;
  assign w_lock_loss = ~pll_lock_i & (r_state == ST_RELEASE || r_state == ST_RUN);
  assign w_evt = w_src | w_lock_loss;
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx = '0;
    w_lock_nx = '0;
    w_stage_nx = '0;
    w_rst_n_nx = r_rst_n;
    w_ready_nx = r_ready;
    w_cause_nx = r_cause;
    if (r_state == ST_ASSERT) begin
      w_hold_nx = w_src ? '0 : r_hold + 1'b1;
      if (!w_src && r_hold == H_MAX) begin
        w_state_nx = ST_WAIT_LOCK;
        w_hold_nx = '0;
      end
    end else if (w_evt) begin
      w_state_nx = ST_ASSERT;
      w_rst_n_nx = '0;
      w_ready_nx = 1'b0;
      w_cause_nx = w_btn_evt ? RST_CAUSE_BTN : w_lock_loss ? RST_CAUSE_LOCK : RST_CAUSE_SW;
    end else if (r_state == ST_WAIT_LOCK) begin
      w_lock_nx = pll_lock_i ? r_lock + 1'b1 : '0;
      if (pll_lock_i && r_lock == L_MAX) begin
        w_state_nx = ST_RELEASE;
        w_lock_nx = '0;
        w_rst_n_nx[0] = 1'b1;
      end
    end else if (r_state == ST_RELEASE) begin
      if (r_stage == S_TOP) begin
        w_state_nx = ST_RUN;
        w_ready_nx = 1'b1;
        w_stage_nx = r_stage;
      end else begin
        w_stage_nx = r_stage + 1'b1;
        for (int k = 1; k < NUM_RST; k++)
          if (w_stage_nx == SW'(k * STAGE_GAP)) w_rst_n_nx[k] = 1'b1;
      end
    end else begin
      w_stage_nx = r_stage;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_ASSERT;
      r_hold <= '0;
      r_lock <= '0;
      r_stage <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_cause <= RST_CAUSE_POR;
    end else begin
      r_state <= w_state_nx;
      r_hold <= w_hold_nx;
      r_lock <= w_lock_nx;
      r_stage <= w_stage_nx;
      r_rst_n <= w_rst_n_nx;
      r_ready <= w_ready_nx;
      r_cause <= w_cause_nx;
    end
  end
  assign rst_n_o = r_rst_n;
  assign sys_ready_o = r_ready;
  assign rst_cause_o = r_cause;
endmodule

// File: tb/tb_retrosoc_rst_seq.sv
// tb_retrosoc_rst_seq: directed scenarios with cycle-stamped expectations checked by a scoreboard monitor
module tb_retrosoc_rst_seq;
  typedef struct {
    int cyc;
    logic [3:0] rst_n;
    logic rdy;
    logic [1:0] cause;
    string name;
  } exp_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_rst_n_i = 1'b1;
  logic pll_lock_i = 1'b1;
  logic sw_rst_i = 1'b0;
  logic [3:0] rst_n_o;
  logic sys_ready_o;
  logic [1:0] rst_cause_o;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  exp_t q[$];
  exp_t m_e;
  retrosoc_rst_seq dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .btn_rst_n_i(btn_rst_n_i),
    .pll_lock_i(pll_lock_i),
    .sw_rst_i(sw_rst_i),
    .rst_n_o(rst_n_o),
    .sys_ready_o(sys_ready_o),
    .rst_cause_o(rst_cause_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic expect_at(input int c, input logic [3:0] r, input logic rd, input logic [1:0] ca, input string nm);
    exp_t e;
    int i;
    e = '{c, r, rd, ca, nm};
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask
  always @(negedge clk_i) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_chk++;
      if (m_e.cyc == cyc && rst_n_o == m_e.rst_n && sys_ready_o == m_e.rdy && rst_cause_o == m_e.cause)
        n_pass++;
      else
        $display("FAIL %s cyc %0d (due %0d): got rst_n=%b rdy=%b cause=%b, want rst_n=%b rdy=%b cause=%b",
                 m_e.name, cyc, m_e.cyc, rst_n_o, sys_ready_o, rst_cause_o, m_e.rst_n, m_e.rdy, m_e.cause);
    end
  end
  initial begin
    int c0, g, f, r, l, m, c2;
    expect_at(2, 4'b0000, 1'b0, 2'b00, "reset_state");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    c0 = cyc;
    expect_at(c0+1,  4'b0000, 1'b0, 2'b00, "por_hold");
    expect_at(c0+23, 4'b0000, 1'b0, 2'b00, "por_pre0");
    expect_at(c0+24, 4'b0001, 1'b0, 2'b00, "por_rel0");
    expect_at(c0+31, 4'b0001, 1'b0, 2'b00, "por_pre1");
    expect_at(c0+32, 4'b0011, 1'b0, 2'b00, "por_rel1");
    expect_at(c0+40, 4'b0111, 1'b0, 2'b00, "por_rel2");
    expect_at(c0+48, 4'b1111, 1'b0, 2'b00, "por_rel3");
    expect_at(c0+49, 4'b1111, 1'b1, 2'b00, "por_run");
    g = c0 + 60;
    wait_to(g - 5);
    expect_at(g+20, 4'b1111, 1'b1, 2'b00, "glitch_a");
    expect_at(g+30, 4'b1111, 1'b1, 2'b00, "glitch_b");
    wait_to(g); btn_rst_n_i = 1'b0;
    wait_to(g + 10); btn_rst_n_i = 1'b1;
    f = c0 + 100;
    r = f + 20;
    wait_to(f - 5);
    expect_at(f+17, 4'b1111, 1'b1, 2'b00, "btn_pre");
    expect_at(f+18, 4'b0000, 1'b0, 2'b01, "btn_assert");
    expect_at(r+25, 4'b0000, 1'b0, 2'b01, "btn_hold_end");
    expect_at(r+26, 4'b0001, 1'b0, 2'b01, "btn_rel0");
    expect_at(r+50, 4'b1111, 1'b0, 2'b01, "btn_rel3");
    expect_at(r+51, 4'b1111, 1'b1, 2'b01, "btn_run");
    wait_to(f); btn_rst_n_i = 1'b0;
    wait_to(r); btn_rst_n_i = 1'b1;
    l = c0 + 200;
    wait_to(l - 5);
    expect_at(l,    4'b1111, 1'b1, 2'b01, "lock_pre");
    expect_at(l+1,  4'b0000, 1'b0, 2'b10, "lock_assert");
    expect_at(l+24, 4'b0000, 1'b0, 2'b10, "lock_hold_end");
    expect_at(l+25, 4'b0001, 1'b0, 2'b10, "lock_rel0");
    expect_at(l+33, 4'b0011, 1'b0, 2'b10, "lock_rel1");
    expect_at(l+35, 4'b0011, 1'b0, 2'b10, "sw_pre");
    expect_at(l+36, 4'b0000, 1'b0, 2'b11, "sw_assert");
    expect_at(l+59, 4'b0000, 1'b0, 2'b11, "sw_hold_end");
    expect_at(l+60, 4'b0001, 1'b0, 2'b11, "sw_rel0");
    expect_at(l+68, 4'b0011, 1'b0, 2'b11, "sw_rel1");
    expect_at(l+76, 4'b0111, 1'b0, 2'b11, "sw_rel2");
    expect_at(l+84, 4'b1111, 1'b0, 2'b11, "sw_rel3");
    expect_at(l+85, 4'b1111, 1'b1, 2'b11, "sw_run");
    wait_to(l); pll_lock_i = 1'b0;
    wait_to(l + 1); pll_lock_i = 1'b1;
    wait_to(l + 35); sw_rst_i = 1'b1;
    wait_to(l + 36); sw_rst_i = 1'b0;
    m = c0 + 300;
    c2 = m + 48;
    wait_to(m - 15);
    expect_at(m,     4'b1111, 1'b1, 2'b11, "both_pre");
    expect_at(m+1,   4'b0000, 1'b0, 2'b10, "both_assert");
    expect_at(m+30,  4'b0000, 1'b0, 2'b10, "both_btn_hold");
    expect_at(m+35,  4'b0000, 1'b0, 2'b10, "both_hold_end");
    expect_at(m+36,  4'b0001, 1'b0, 2'b10, "both_rel0");
    expect_at(m+44,  4'b0011, 1'b0, 2'b10, "both_rel1");
    expect_at(m+47,  4'b0011, 1'b0, 2'b10, "rstmid_pre");
    expect_at(c2,    4'b0000, 1'b0, 2'b00, "rstmid_reset");
    expect_at(c2+23, 4'b0000, 1'b0, 2'b00, "rstmid_pre0");
    expect_at(c2+24, 4'b0001, 1'b0, 2'b00, "rstmid_rel0");
    expect_at(c2+48, 4'b1111, 1'b0, 2'b00, "rstmid_rel3");
    expect_at(c2+49, 4'b1111, 1'b1, 2'b00, "rstmid_run");
    wait_to(m - 10); btn_rst_n_i = 1'b0;
    wait_to(m); sw_rst_i = 1'b1; pll_lock_i = 1'b0;
    wait_to(m + 1); sw_rst_i = 1'b0; pll_lock_i = 1'b1;
    wait_to(m + 10); btn_rst_n_i = 1'b1;
    wait_to(m + 47); rst_i = 1'b1;
    wait_to(c2); rst_i = 1'b0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    foreach (q[i]) $display("FAIL timeout %s: still pending, due cyc %0d, now cyc %0d", q[i].name, q[i].cyc, cyc);
    if (rst_n_o !== 4'b1111 || sys_ready_o !== 1'b1 || rst_cause_o !== 2'b00)
      $display("FAIL final state: rst_n=%b rdy=%b cause=%b", rst_n_o, sys_ready_o, rst_cause_o);
    if (n_pass == n_chk && q.size() == 0)
      $display("PASS %0d/%0d checks passed", n_pass, n_chk);
    else
      $display("FAIL %0d/%0d checks passed", n_pass, n_chk + q.size());
    $finish;
  end
endmodule
